// File: rtl/fifo_wr_arbiter.sv
// Shares one async-FIFO write port between NUM_REQ requesters. Each request is a 1- or 2-byte atomic burst.
// Arbitration is round-robin; define FIFO_WR_ARB_FIXED_PRIO_EN for fixed priority where the lowest index wins.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2,
    parameter int IDX_W      = 3
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_len,
    input  logic [NUM_REQ*2*DATA_WIDTH-1:0] req_data,
    input  logic                            wfull,
    output logic                            winc,
    output logic [DATA_WIDTH-1:0]           wdata,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            busy
);

    localparam int SLOTS = 2 ** IDX_W;
    localparam int DW2   = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI, DONE} state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   owner_reg;
    logic [IDX_W-1:0]   last_reg;
    logic               len_reg;
    logic [DW2-1:0]     data_reg;
    logic [NUM_REQ-1:0] gnt_reg;
    logic               busy_reg;

    logic [IDX_W-1:0]   winner;
    logic               found;
    logic [DW2-1:0]     payload [SLOTS];
    logic [SLOTS-1:0]   req_ext;
    logic [SLOTS-1:0]   len_ext;
    logic [NUM_REQ-1:0] owner_onehot;

    // Pad the per-requester views up to 2^IDX_W so an owner index can address them directly.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < NUM_REQ) begin : g_live
                assign payload[gi] = req_data[gi*DW2 +: DW2];
                assign req_ext[gi] = req[gi];
                assign len_ext[gi] = req_len[gi];
            end else begin : g_pad
                assign payload[gi] = '0;
                assign req_ext[gi] = 1'b0;
                assign len_ext[gi] = 1'b0;
            end
        end
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign owner_onehot[gi] = (owner_reg == IDX_W'(gi));
        end
    endgenerate

`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                winner = IDX_W'(k);
                found  = 1'b1;
            end
        end
    end
`else
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan from the farthest offset down so the candidate nearest last+1 is the one left standing.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = int'(last_reg) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (req_ext[cand_idx]) begin
                winner = cand_idx;
                found  = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
            owner_reg <= '0;
            last_reg  <= IDX_W'(NUM_REQ - 1);
            len_reg   <= 1'b0;
            data_reg  <= '0;
            gnt_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        owner_reg <= winner;
                        len_reg   <= len_ext[winner];
                        data_reg  <= payload[winner];
`ifndef FIFO_WR_ARB_FIXED_PRIO_EN
                        last_reg  <= winner;
`endif
                        state_reg <= SEND_LO;
                        busy_reg  <= 1'b1;
                    end
                end
                SEND_LO: begin
                    if (!wfull) begin
                        if (len_reg) begin
                            state_reg <= SEND_HI;
                        end else begin
                            state_reg <= DONE;
                            gnt_reg   <= owner_onehot;
                        end
                    end
                end
                SEND_HI: begin
                    if (!wfull) begin
                        state_reg <= DONE;
                        gnt_reg   <= owner_onehot;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    gnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Write strobe follows wfull in the same cycle so a stalled byte is simply retried.
    assign winc = ((state_reg == SEND_LO) || (state_reg == SEND_HI)) && !wfull;

    always_comb begin
        wdata = '0;
        case (state_reg)
            SEND_LO: wdata = data_reg[DATA_WIDTH-1:0];
            SEND_HI: wdata = data_reg[DW2-1:DATA_WIDTH];
            default: wdata = '0;
        endcase
    end

    assign gnt  = gnt_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: single bursts, round-robin order, wfull stalls,
// mid-burst reset and a depth-8 FIFO model with a stalled reader.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  req_len;
    logic [31:0] req_data;
    logic        wfull;
    logic        winc;
    logic [7:0]  wdata;
    logic [1:0]  gnt;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    // FIFO model used by the last scenario
    logic        fifo_en = 1'b0;
    logic        wfull_force = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  mem [8];
    logic [2:0]  wp = '0;
    logic [2:0]  rp = '0;
    int          cnt = 0;
    int          wr_total = 0;
    logic [7:0]  pop_log [16];
    int          pop_n = 0;
    int          winc_cnt = 0;

    fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(2), .IDX_W(3)) dut (
        .CLK      (clk),
        .RST      (rst_n),
        .req      (req),
        .req_len  (req_len),
        .req_data (req_data),
        .wfull    (wfull),
        .winc     (winc),
        .wdata    (wdata),
        .gnt      (gnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    assign wfull = fifo_en ? (cnt == 8) : wfull_force;

    always @(posedge clk) begin
        if (fifo_en) begin
            if (winc) begin
                mem[wp]  <= wdata;
                wp       <= wp + 3'd1;
                wr_total <= wr_total + 1;
            end
            if (rd_en && cnt != 0) begin
                if (pop_n < 16) pop_log[pop_n] <= mem[rp];
                pop_n <= pop_n + 1;
                rp    <= rp + 3'd1;
            end
            cnt <= cnt + (winc ? 1 : 0) - ((rd_en && cnt != 0) ? 1 : 0);
        end
    end

    always @(negedge clk) begin
        if (winc) winc_cnt <= winc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Inputs change 3 time units after the edge; outputs are sampled one unit later.
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    int exp_owner [4];
    int snap;
    int k;
    int viol;
    int wr_before;
    bit saw_gnt;

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_len  = '0;
        req_data = '0;
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
        exp_owner = '{0, 0, 0, 0};
`else
        exp_owner = '{0, 1, 0, 1};
`endif
        tick(); tick(); #1;
        check("rst_winc", {31'd0, winc}, 0);
        check("rst_wdata", {24'd0, wdata}, 0);
        check("rst_gnt", {30'd0, gnt}, 0);
        check("rst_busy", {31'd0, busy}, 0);

        // single byte from requester 0
        tick(); rst_n = 1'b1;
        tick(); req = 2'b01; req_len = 2'b00; req_data[15:0] = 16'h12A5; #1;
        check("t1_idle_winc", {31'd0, winc}, 0);
        tick(); #1;
        check("t1_winc", {31'd0, winc}, 1);
        check("t1_wdata", {24'd0, wdata}, 32'hA5);
        check("t1_busy1", {31'd0, busy}, 1);
        check("t1_nognt", {30'd0, gnt}, 0);
        tick(); #1;
        check("t1_gnt", {30'd0, gnt}, 32'h1);
        check("t1_winc_off", {31'd0, winc}, 0);
        check("t1_busy2", {31'd0, busy}, 1);
        tick(); req = 2'b00; #1;
        check("t1_busy_end", {31'd0, busy}, 0);
        check("t1_gnt_end", {30'd0, gnt}, 0);

        // two bytes from requester 1
        tick(); req = 2'b10; req_len = 2'b10; req_data[31:16] = 16'hBEEF; #1;
        tick(); #1;
        check("t2_lo", {23'd0, winc, wdata}, 32'h1EF);
        tick(); #1;
        check("t2_hi", {23'd0, winc, wdata}, 32'h1BE);
        tick(); #1;
        check("t2_gnt", {30'd0, gnt}, 32'h2);
        check("t2_winc_off", {31'd0, winc}, 0);
        tick(); req = 2'b00; #1;
        check("t2_busy_end", {31'd0, busy}, 0);

        // both requesting continuously
        tick(); req = 2'b11; req_len = 2'b00; req_data = {16'h0022, 16'h0011}; #1;
        for (int b = 0; b < 4; b++) begin
            tick(); #1;
            check($sformatf("t3_wr%0d", b), {23'd0, winc, wdata},
                  (exp_owner[b] == 0) ? 32'h111 : 32'h122);
            tick(); #1;
            check($sformatf("t3_gnt%0d", b), {30'd0, gnt}, (exp_owner[b] == 0) ? 32'h1 : 32'h2);
            tick(); if (b == 3) req = 2'b00; #1;
            check($sformatf("t3_idle%0d", b), {31'd0, busy}, 0);
        end

        // wfull for 3 cycles between bytes
        tick(); req = 2'b01; req_len = 2'b01; req_data[15:0] = 16'hC33C; #1;
        snap = winc_cnt;
        tick(); #1;
        check("t4_lo", {23'd0, winc, wdata}, 32'h13C);
        for (int s = 0; s < 3; s++) begin
            tick(); wfull_force = 1'b1; #1;
            check($sformatf("t4_stall%0d", s), {30'd0, busy, winc}, 32'h2);
        end
        tick(); wfull_force = 1'b0; #1;
        check("t4_hi", {23'd0, winc, wdata}, 32'h1C3);
        tick(); #1;
        check("t4_gnt", {30'd0, gnt}, 32'h1);
        tick(); req = 2'b00; #1;
        check("t4_winc_total", winc_cnt - snap, 2);

        // reset during SEND_HI
        tick(); req = 2'b10; req_len = 2'b10; req_data[31:16] = 16'hBEEF; #1;
        tick(); #1;
        tick(); #1;
        check("t5_hi", {23'd0, winc, wdata}, 32'h1BE);
        rst_n = 1'b0; #1;
        check("t5_rst_out", {20'd0, winc, wdata, gnt, busy}, 0);
        tick(); #1;
        check("t5_rst_hold", {20'd0, winc, wdata, gnt, busy}, 0);
        tick(); rst_n = 1'b1; req = 2'b11; req_len = 2'b00; req_data = {16'h0088, 16'h0077}; #1;
        check("t5_nogntpost", {30'd0, gnt}, 0);
        tick(); #1;
        check("t5_first", {23'd0, winc, wdata}, 32'h177);
        tick(); #1;
        check("t5_gnt", {30'd0, gnt}, 32'h1);
        tick(); req = 2'b00; #1;

        // depth-8 FIFO with stalled reader, six 2-byte bursts of 1..12
        tick(); fifo_en = 1'b1; req = 2'b01; req_len = 2'b01; req_data[15:0] = {8'd2, 8'd1}; #1;
        k = 0; viol = 0; wr_before = -1; saw_gnt = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (saw_gnt) begin
                k++;
                saw_gnt = 1'b0;
                if (k == 6) req = 2'b00;
                else req_data[15:0] = {8'(2 * k + 2), 8'(2 * k + 1)};
            end
            rd_en = (c >= 40);
            #1;
            if (wfull && winc) viol++;
            if (gnt[0]) saw_gnt = 1'b1;
            if (c == 39) wr_before = wr_total;
            if (k == 6 && pop_n >= 12) break;
        end
        check("t6_winc_while_full", viol, 0);
        check("t6_writes_stalled", wr_before, 8);
        check("t6_bursts", k, 6);
        check("t6_pop_count", pop_n, 12);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t6_byte%0d", i), {24'd0, pop_log[i]}, i + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
